// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Purpose  : Shared types and constants for the 5-stage pipeline hazard
//            controller: FSM state encoding, register-index width and the
//            canonical control vectors driven in each pipeline situation.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_reg_idx_w = 5;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_LU_BUBBLE = 2'd2,
        ST_FREEZE    = 2'd3
    } state_t;

    // One bit per pipeline control output; flush bits win over write bits
    // inside the pipeline registers themselves.
    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Free-running pipeline: everything advances, nothing is squashed.
    localparam ctrl_t c_ctrl_run = '{
        pc_write: 1'b1, pc_sel: 1'b0,
        if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_flush: 1'b0
    };

    // Priming after reset: PC held, every stage loads a bubble.
    localparam ctrl_t c_ctrl_init = '{
        pc_write: 1'b0, pc_sel: 1'b0,
        if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
        mem_wb_flush: 1'b1
    };

    // Data-memory wait: whole front of the pipe holds, MEM_WB gets a bubble
    // so the stalled access is not retired twice.
    localparam ctrl_t c_ctrl_freeze = '{
        pc_write: 1'b0, pc_sel: 1'b0,
        if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
        mem_wb_flush: 1'b1
    };

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard comparator. Flags when the
//            instruction in ID reads the destination of a load sitting in EX.
// Ports    : id_rs1/id_rs2      - source registers of the ID instruction
//            id_uses_rs1/rs2    - ID instruction actually reads that source
//            ex_mem_read        - EX instruction is a load
//            ex_rd              - destination of the EX instruction
//            mask               - suppresses detection (bubble already issued)
//            hazard             - stall request
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [c_reg_idx_w-1:0] id_rs1,
    input  logic [c_reg_idx_w-1:0] id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [c_reg_idx_w-1:0] ex_rd,
    input  logic                   mask,
    output logic                   hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is hard-wired to zero, so a load "into" it never creates a dependency.
    assign hazard = !mask && ex_mem_read && (ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//            Primes the pipe after reset, inserts load-use bubbles, squashes
//            wrong-path instructions on taken branches and freezes on data
//            memory waits. Keeps saturating stall/redirect counters.
// Ports    : clk, reset (sync, active-high)
//            id_*/ex_*/mem_busy  - hazard sources from ID, EX and MEM
//            pc_write, pc_sel    - PC load enable and branch-mux select
//            *_write, *_flush    - pipeline-register load enables / bubbles
//            pipe_ready          - priming complete
//            stall_cycles        - cycles with PC held outside priming
//            redirect_count      - taken-branch redirects
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [c_reg_idx_w-1:0] id_rs1,
    input  logic [c_reg_idx_w-1:0] id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [c_reg_idx_w-1:0] ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_write,
    output logic                   pc_sel,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   pipe_ready,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       redirect_count
);

    localparam logic [7:0] c_init_last = 8'(INIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;
    ctrl_t            ctrl;
    logic             w_hazard;
    logic             w_hazard_mask;

    // A load-use bubble is already in EX while in LU_BUBBLE; re-detecting the
    // same pair would insert a second, useless bubble.
    assign w_hazard_mask = (state_q == ST_LU_BUBBLE) || (state_q == ST_INIT);

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .mask        (w_hazard_mask),
        .hazard      (w_hazard)
    );

    always_comb begin
        ctrl             = c_ctrl_run;
        state_d          = ST_RUN;
        init_cnt_d       = init_cnt_q;
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;

        if (state_q == ST_INIT) begin
            ctrl       = c_ctrl_init;
            init_cnt_d = init_cnt_q + 8'd1;
            state_d    = (init_cnt_q == c_init_last) ? ST_RUN : ST_INIT;
        end else begin
            // RUN, LU_BUBBLE and FREEZE share one decision tree; FREEZE
            // without mem_busy behaves exactly like RUN in the same cycle.
            if (mem_busy) begin
                ctrl    = c_ctrl_freeze;
                state_d = ST_FREEZE;
            end else if (ex_branch_taken) begin
                // Any load-use victim in ID is squashed here, so no stall.
                ctrl.pc_sel      = 1'b1;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                if (redirect_count_q != '1) begin
                    redirect_count_d = redirect_count_q + CNT_W'(1);
                end
            end else if (w_hazard) begin
                ctrl.pc_write    = 1'b0;
                ctrl.if_id_write = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                state_d          = ST_LU_BUBBLE;
            end

            if (!ctrl.pc_write && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_INIT;
            init_cnt_q       <= '0;
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            init_cnt_q       <= init_cnt_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_write       = ctrl.pc_write;
    assign pc_sel         = ctrl.pc_sel;
    assign if_id_write    = ctrl.if_id_write;
    assign id_ex_write    = ctrl.id_ex_write;
    assign ex_mem_write   = ctrl.ex_mem_write;
    assign if_id_flush    = ctrl.if_id_flush;
    assign id_ex_flush    = ctrl.id_ex_flush;
    assign ex_mem_flush   = ctrl.ex_mem_flush;
    assign mem_wb_flush   = ctrl.mem_wb_flush;
    assign pipe_ready     = (state_q != ST_INIT);
    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. Drives a wide
//            (CNT_W=32) and a narrow (CNT_W=4) instance from the same inputs
//            and compares both against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int INIT_N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_busy;

    logic        w_pc_write, w_pc_sel, w_if_id_write, w_id_ex_write, w_ex_mem_write;
    logic        w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush, w_pipe_ready;
    logic [31:0] w_stall_cycles, w_redirect_count;

    logic        n_pc_write, n_pc_sel, n_if_id_write, n_id_ex_write, n_ex_mem_write;
    logic        n_if_id_flush, n_id_ex_flush, n_ex_mem_flush, n_mem_wb_flush, n_pipe_ready;
    logic [3:0]  n_stall_cycles, n_redirect_count;

    logic [9:0]  obs_w, obs_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_N), .CNT_W(32)) dut_w (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(w_pc_write), .pc_sel(w_pc_sel),
        .if_id_write(w_if_id_write), .id_ex_write(w_id_ex_write), .ex_mem_write(w_ex_mem_write),
        .if_id_flush(w_if_id_flush), .id_ex_flush(w_id_ex_flush), .ex_mem_flush(w_ex_mem_flush),
        .mem_wb_flush(w_mem_wb_flush), .pipe_ready(w_pipe_ready),
        .stall_cycles(w_stall_cycles), .redirect_count(w_redirect_count)
    );

    pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_N), .CNT_W(4)) dut_n (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(n_pc_write), .pc_sel(n_pc_sel),
        .if_id_write(n_if_id_write), .id_ex_write(n_id_ex_write), .ex_mem_write(n_ex_mem_write),
        .if_id_flush(n_if_id_flush), .id_ex_flush(n_id_ex_flush), .ex_mem_flush(n_ex_mem_flush),
        .mem_wb_flush(n_mem_wb_flush), .pipe_ready(n_pipe_ready),
        .stall_cycles(n_stall_cycles), .redirect_count(n_redirect_count)
    );

    // {pc_write, pc_sel, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, pipe_ready}
    assign obs_w = {w_pc_write, w_pc_sel, w_if_id_write, w_id_ex_write, w_ex_mem_write,
                    w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush, w_pipe_ready};
    assign obs_n = {n_pc_write, n_pc_sel, n_if_id_write, n_id_ex_write, n_ex_mem_write,
                    n_if_id_flush, n_id_ex_flush, n_ex_mem_flush, n_mem_wb_flush, n_pipe_ready};

    // Reference model state
    int          checks   = 0;
    int          failures = 0;
    bit          m_known  = 1'b0;
    int          m_init_left = 0;
    bit          m_bubble = 1'b0;
    logic [63:0] m_stall_w = '0, m_redir_w = '0, m_stall_n = '0, m_redir_n = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction

    // One clock cycle: predict outputs from the current inputs, compare at the
    // falling edge, then advance the model across the rising edge.
    task automatic step(input string tag);
        logic [9:0] e;
        bit hz, nb, sc, rc;
        hz = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        nb = 1'b0; sc = 1'b0; rc = 1'b0;
        if (m_init_left > 0)              e = 10'b0_0_000_1111_0;
        else if (mem_busy)                e = 10'b0_0_000_0001_1;
        else if (ex_branch_taken) begin   e = 10'b1_1_111_1100_1; rc = 1'b1; end
        else if (!m_bubble && hz) begin   e = 10'b0_0_011_0100_1; nb = 1'b1; end
        else                              e = 10'b1_0_111_0000_1;
        sc = (m_init_left == 0) && !e[9];

        @(negedge clk);
        if (m_known) begin
            chk({tag, ":ctl_w"},   {54'd0, obs_w}, {54'd0, e});
            chk({tag, ":ctl_n"},   {54'd0, obs_n}, {54'd0, e});
            chk({tag, ":stall_w"}, {32'd0, w_stall_cycles},   m_stall_w);
            chk({tag, ":redir_w"}, {32'd0, w_redirect_count}, m_redir_w);
            chk({tag, ":stall_n"}, {60'd0, n_stall_cycles},   m_stall_n);
            chk({tag, ":redir_n"}, {60'd0, n_redirect_count}, m_redir_n);
        end

        @(posedge clk);
        #1;
        if (reset) begin
            m_known = 1'b1; m_init_left = INIT_N; m_bubble = 1'b0;
            m_stall_w = '0; m_redir_w = '0; m_stall_n = '0; m_redir_n = '0;
        end else if (m_known) begin
            if (m_init_left > 0) m_init_left--;
            m_bubble = nb;
            if (sc) begin
                m_stall_w = sat_inc(m_stall_w, 64'hFFFF_FFFF);
                m_stall_n = sat_inc(m_stall_n, 64'd15);
            end
            if (rc) begin
                m_redir_w = sat_inc(m_redir_w, 64'hFFFF_FFFF);
                m_redir_n = sat_inc(m_redir_n, 64'd15);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

        // Reset and priming
        step("rst0");
        step("rst1");
        reset = 1'b0;
        for (int i = 0; i < INIT_N; i++) step("init");
        step("first_run");
        chk("ready_after_init", {63'd0, w_pipe_ready}, 64'd1);

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        step("lu_stall");
        step("lu_bubble");
        ex_mem_read = 1'b0;
        step("lu_after");
        chk("lu_stall_cnt", {32'd0, w_stall_cycles}, 64'd1);

        // No hazard: x0 destination, then source not used
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step("lu_x0");
        ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        step("lu_nouse");
        chk("no_extra_stall", {32'd0, w_stall_cycles}, 64'd1);

        // Taken branch together with a load-use hazard
        id_uses_rs2 = 1'b1; ex_branch_taken = 1'b1;
        step("br_lu");
        ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
        step("post_br");
        chk("redir_cnt", {32'd0, w_redirect_count}, 64'd1);

        // Memory wait with a pending taken branch
        ex_branch_taken = 1'b1; mem_busy = 1'b1;
        repeat (3) step("freeze");
        mem_busy = 1'b0;
        step("freeze_release_br");
        ex_branch_taken = 1'b0;
        step("post_freeze");
        chk("freeze_stall_cnt", {32'd0, w_stall_cycles}, 64'd4);

        // Saturation of the narrow counter, then reset during FREEZE
        mem_busy = 1'b1;
        repeat (20) step("sat");
        chk("stall_sat_n", {60'd0, n_stall_cycles}, 64'd15);
        reset = 1'b1;
        step("rst_in_freeze");
        reset = 1'b0; mem_busy = 1'b0;
        step("post_rst");
        chk("post_rst_stall", {32'd0, w_stall_cycles}, 64'd0);

        // Randomized traffic on a small register set to make hazards frequent
        repeat (500) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives PC write-enable, the branch-mux select (to_branch) and the write-enable/flush of IF_ID, ID_EX, EX_MEM and MEM_WB.
- Sequences post-reset pipeline priming, load-use stalls, taken-branch squashes and data-memory wait freezes.
- Keeps saturating stall and redirect counters for performance debug.

Parameters:
- INIT_CYCLES, 4: cycles after reset during which the PC is held and all pipeline registers are flushed (range 1..255).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- ex_mem_read  in  1  the EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_busy  in  1  data memory not ready; the MEM access must be held
- pc_write  out  1  PC register load enable
- pc_sel  out  1  branch-mux select (1 = branch target)
- if_id_write, id_ex_write, ex_mem_write  out  1 each  pipeline-register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (flush wins over write)
- pipe_ready  out  1  high once INIT has completed
- stall_cycles  out  CNT_W  cycles with pc_write=0 outside INIT
- redirect_count  out  CNT_W  number of taken-branch redirects

Behaviour:
- All control outputs are combinational from the registered state and the current inputs. Pipeline registers act on them at the next clk edge.
- States: INIT, RUN, LU_BUBBLE, FREEZE. On reset: state=INIT, init counter=0, both performance counters=0. Reset asserted mid-operation does the same, from any state.
- Default (RUN, no event): pc_write=1, all *_write=1, all flushes=0, pc_sel=0.
- INIT:
  - Outputs: pc_write=0, all *_write=0, all four flushes=1, pc_sel=0, pipe_ready=0.
  - The counter increments each cycle; after INIT_CYCLES cycles in INIT, go to RUN.
  - pipe_ready=1 in every state other than INIT.
- Event priority when not in INIT: mem_busy > ex_branch_taken > load-use.
- FREEZE:
  - When mem_busy=1 (from RUN or LU_BUBBLE): pc_write=0, all *_write=0, mem_wb_flush=1, other flushes=0, pc_sel=0. Next state is FREEZE.
  - Branch and load-use inputs are ignored while frozen.
  - In FREEZE with mem_busy=0: evaluate exactly as RUN in that same cycle, including the next-state choice.
- Taken branch (ex_branch_taken=1, mem_busy=0): pc_sel=1, pc_write=1, if_id_flush=1, id_ex_flush=1; other writes stay 1. Next state RUN; redirect_count+1.
  - A simultaneous load-use hazard is discarded because its victim is squashed.
- Load-use hazard:
  - Hazard = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Evaluated only in RUN or FREEZE→RUN. In LU_BUBBLE the detector is masked.
  - On a hazard: pc_write=0, if_id_write=0, id_ex_flush=1, others default. Next state LU_BUBBLE.
- LU_BUBBLE: default RUN outputs (the bubble is now in EX). A taken branch or mem_busy is honoured per priority. Next state RUN unless FREEZE applies.
- Counters:
  - stall_cycles increments on every non-INIT cycle with pc_write=0, including FREEZE and load-use cycles.
  - Both counters saturate at all-ones and never wrap.
- Register x0 never produces a hazard.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state enumeration (2-bit: INIT=0, RUN=1, LU_BUBBLE=2, FREEZE=3);
  - register-index width 5;
  - a localparam bundle for the default control vector.
- One sub-module, hazard_detect: purely combinational load-use comparator with inputs id_rs1/rs2, uses flags, ex_mem_read, ex_rd and a mask; output hazard.
- FSM, init counter and performance counters stay in the top module.

Test Plan:
- Reset for 2 cycles, then release -> INIT_CYCLES=4 cycles with pc_write=0 and all flushes=1, pipe_ready=0; on the 5th cycle pipe_ready=1 and pc_write=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then default outputs; stall_cycles=1.
- Same as the load-use case but ex_rd=0, or id_uses_rs2=0 -> no stall; stall_cycles stays 0.
- ex_branch_taken=1 together with a load-use hazard -> pc_sel=1, if_id_flush=id_ex_flush=1, pc_write=1, no stall; redirect_count=1.
- mem_busy=1 for 3 cycles with ex_branch_taken=1 held -> 3 frozen cycles (all writes 0, mem_wb_flush=1, pc_sel=0), then the redirect fires on the 4th cycle; stall_cycles=3.
- With CNT_W=4 preload, force 20 frozen cycles -> stall_cycles saturates at 15; reset asserted during FREEZE -> next cycle is INIT outputs and counters=0.
